// File: rtl/qdec_pkg.sv
// Shared types and the phase-transition decode function for the quadrature decoder.
// The phase encoding is the raw {A,B} pair, so a synchronized pair can be cast
// directly to phase_e.
package qdec_pkg;

   typedef enum logic [1:0] {
      PH00 = 2'b00,
      PH10 = 2'b10,
      PH11 = 2'b11,
      PH01 = 2'b01
   } phase_e;

   typedef enum logic [1:0] {
      STEP_NONE    = 2'd0,
      STEP_UP      = 2'd1,
      STEP_DOWN    = 2'd2,
      STEP_ILLEGAL = 2'd3
   } step_e;

   // Classify one phase transition.
   // Up order is 00 -> 10 -> 11 -> 01 -> 00, so A leads B.
   // A transition that flips both bits cannot be assigned a direction.
   function automatic step_e decode_step(input phase_e prev, input phase_e curr);
      step_e    result;
      phase_e   up_next;
      result  = STEP_NONE;
      up_next = PH00;
      case (prev)
         PH00:    up_next = PH10;
         PH10:    up_next = PH11;
         PH11:    up_next = PH01;
         PH01:    up_next = PH00;
         default: up_next = PH00;
      endcase
      if (prev == curr) begin
         result = STEP_NONE;
      end else if ((prev ^ curr) == 2'b11) begin
         result = STEP_ILLEGAL;
      end else if (curr == up_next) begin
         result = STEP_UP;
      end else begin
         result = STEP_DOWN;
      end
      return result;
   endfunction

endpackage

// File: rtl/qdec_sync.sv
// Per-channel input synchronizer for the quadrature decoder.
// SYNC_STAGES must be at least 2. The flops carry no reset and sample continuously.
// Optional macro QDEC_GLITCH_FILTER_EN adds a two-cycle stability filter behind
// the synchronizer, which adds one cycle of latency.
module qdec_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic async_in,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   // Shift the raw input one stage deeper into the synchronizer chain.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
   end

   // Synchronizer chain register.
   always_ff @(posedge clk) begin
      sync_q <= sync_d;
   end

`ifdef QDEC_GLITCH_FILTER_EN
   logic last_q;
   logic last_d;
   logic held_q;
   logic held_d;
   logic filt;

   // Accept the synchronized value only once it matches the previous cycle's value.
   // Otherwise keep presenting the last accepted value.
   always_comb begin
      last_d   = sync_q[SYNC_STAGES-1];
      filt     = (sync_q[SYNC_STAGES-1] == last_q) ? sync_q[SYNC_STAGES-1] : held_q;
      held_d   = filt;
      sync_out = filt;
   end

   // Filter history and accepted-value registers.
   always_ff @(posedge clk) begin
      last_q <= last_d;
      held_q <= held_d;
   end
`else
   // Without the filter, the last synchronizer stage drives the decoder directly.
   always_comb begin
      sync_out = sync_q[SYNC_STAGES-1];
   end
`endif

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder with a loadable wrap-around position counter.
// A/B are synchronized, and each phase change is compared against the previous phase.
// The result is a step/dir/err event that also drives the counter.
// Optional macro QDEC_GLITCH_FILTER_EN enables the input stability filter in qdec_sync.
module quad_decoder
   import qdec_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ch_a,
   input  logic             ch_b,
   input  logic             load_n,
   input  logic [WIDTH-1:0] data_load,
   input  logic             ce,
   output logic [WIDTH-1:0] count_out,
   output logic             step,
   output logic             dir,
   output logic             err,
   output logic             max_count,
   output logic             zero
);

   logic             a_sync;
   logic             b_sync;
   phase_e           curr_phase;
   step_e            step_kind;

   phase_e           prev_q;
   phase_e           prev_d;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             step_q;
   logic             step_d;
   logic             dir_q;
   logic             dir_d;
   logic             err_q;
   logic             err_d;

   qdec_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
      .clk      (clk),
      .async_in (ch_a),
      .sync_out (a_sync)
   );

   qdec_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
      .clk      (clk),
      .async_in (ch_b),
      .sync_out (b_sync)
   );

   // Form the current phase, then derive the next phase/counter/event state.
   // A load takes priority over counting, but the decoded step still pulses.
   always_comb begin
      curr_phase = phase_e'({a_sync, b_sync});
      step_kind  = decode_step(prev_q, curr_phase);
      prev_d     = curr_phase;
      step_d     = (step_kind == STEP_UP) || (step_kind == STEP_DOWN);
      err_d      = (step_kind == STEP_ILLEGAL);
      dir_d      = dir_q;
      if (step_kind == STEP_UP) begin
         dir_d = 1'b1;
      end else if (step_kind == STEP_DOWN) begin
         dir_d = 1'b0;
      end
      count_d = count_q;
      if (!load_n) begin
         count_d = data_load;
      end else if (ce && (step_kind == STEP_UP)) begin
         count_d = count_q + WIDTH'(1);
      end else if (ce && (step_kind == STEP_DOWN)) begin
         count_d = count_q - WIDTH'(1);
      end
   end

   // State register. Reset tracks the live phase so no event appears on release.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q  <= curr_phase;
         count_q <= '0;
         step_q  <= 1'b0;
         dir_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         count_q <= count_d;
         step_q  <= step_d;
         dir_q   <= dir_d;
         err_q   <= err_d;
      end
   end

   // Drive outputs from registered state; the flags decode the position value directly.
   always_comb begin
      count_out = count_q;
      step      = step_q;
      dir       = dir_q;
      err       = err_q;
      zero      = (count_q == '0);
      max_count = (count_q == '1);
   end

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder.
// A cycle-level position model runs alongside directed vectors.
module tb_quad_decoder;

   localparam int WIDTH = 4;
   localparam int MOD   = 16;
`ifdef QDEC_GLITCH_FILTER_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             ch_a;
   logic             ch_b;
   logic             load_n;
   logic [WIDTH-1:0] data_load;
   logic             ce;
   logic [WIDTH-1:0] count_out;
   logic             step;
   logic             dir;
   logic             err;
   logic             max_count;
   logic             zero;

   int checks = 0;
   int errors = 0;
   int steps_seen = 0;
   int errs_seen = 0;

   // Model state: position index of each phase along the up sequence 00,10,11,01.
   int         pos_tab [4] = '{0, 3, 1, 2};
   logic [1:0] p1 = 2'b11, p2 = 2'b11, p3 = 2'b11;
   logic [1:0] m_acc = 2'b11;
   logic [1:0] m_prev = 2'b11;
   int         exp_count = 0;
   logic       exp_step = 1'b0, exp_dir = 1'b0, exp_err = 1'b0;
   logic       model_valid = 1'b0;

   quad_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .ch_a      (ch_a),
      .ch_b      (ch_b),
      .load_n    (load_n),
      .data_load (data_load),
      .ce        (ce),
      .count_out (count_out),
      .step      (step),
      .dir       (dir),
      .err       (err),
      .max_count (max_count),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // The model sees each input LAT edges late.
   // A move of 1 along the up sequence counts up, 3 counts down, and 2 is illegal.
   always @(posedge clk) begin
      logic [1:0] curr;
      int         d;
`ifdef QDEC_GLITCH_FILTER_EN
      for (int b = 0; b < 2; b++) begin
         if (p2[b] == p3[b]) m_acc[b] = p2[b];
      end
      curr = m_acc;
`else
      curr = p2;
`endif
      if (rst) begin
         m_prev      = curr;
         exp_count   = 0;
         exp_step    = 1'b0;
         exp_err     = 1'b0;
         exp_dir     = 1'b0;
         model_valid = 1'b1;
      end else begin
         d        = (pos_tab[curr] - pos_tab[m_prev] + 4) % 4;
         exp_step = (d == 1) || (d == 3);
         exp_err  = (d == 2);
         if (d == 1) exp_dir = 1'b1;
         if (d == 3) exp_dir = 1'b0;
         if (!load_n) exp_count = int'(data_load);
         else if (ce && d == 1) exp_count = (exp_count + 1) % MOD;
         else if (ce && d == 3) exp_count = (exp_count + MOD - 1) % MOD;
         m_prev = curr;
      end
      p3 = p2;
      p2 = p1;
      p1 = {ch_a, ch_b};
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (model_valid) begin
         checkOutput("cyc_count", int'(count_out), exp_count);
         checkOutput("cyc_step", int'(step), int'(exp_step));
         checkOutput("cyc_dir", int'(dir), int'(exp_dir));
         checkOutput("cyc_err", int'(err), int'(exp_err));
         checkOutput("cyc_zero", int'(zero), int'(exp_count == 0));
         checkOutput("cyc_max", int'(max_count), int'(exp_count == MOD - 1));
      end
   end

   // Tally event pulses shortly after each rising edge.
   always @(posedge clk) begin
      #1;
      if (step) steps_seen++;
      if (err) errs_seen++;
   end

   task automatic applyStimulus(input logic [1:0] ab, input int hold);
      {ch_a, ch_b} = ab;
      repeat (hold) @(negedge clk);
   endtask

   task automatic doLoad(input logic [WIDTH-1:0] val);
      load_n    = 1'b0;
      data_load = val;
      @(negedge clk);
      load_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      int base;
      rst = 1'b1; ch_a = 1'b1; ch_b = 1'b1; load_n = 1'b1; data_load = '0; ce = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("idle_count", int'(count_out), 0);
      checkOutput("idle_zero", int'(zero), 1);
      checkOutput("idle_steps", steps_seen, 0);
      checkOutput("idle_errs", errs_seen, 0);

      rst = 1'b1;
      {ch_a, ch_b} = 2'b00;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("midrst_errs", errs_seen, 0);
      checkOutput("midrst_steps", steps_seen, 0);

      ce = 1'b1;
      applyStimulus(2'b10, 4); checkOutput("up1", int'(count_out), 1);
      applyStimulus(2'b11, 4); checkOutput("up2", int'(count_out), 2);
      applyStimulus(2'b01, 4); checkOutput("up3", int'(count_out), 3);
      applyStimulus(2'b00, 4); checkOutput("up4", int'(count_out), 4);
      checkOutput("up_dir", int'(dir), 1);
      checkOutput("up_steps", steps_seen, 4);
      checkOutput("model_pin_up", exp_count, 4);

      doLoad(4'hE);
      checkOutput("load_e", int'(count_out), 14);
      applyStimulus(2'b10, 4); checkOutput("wrap_f", int'(count_out), 15);
      checkOutput("wrap_max", int'(max_count), 1);
      applyStimulus(2'b11, 4); checkOutput("wrap_0", int'(count_out), 0);
      checkOutput("wrap_zero", int'(zero), 1);
      applyStimulus(2'b01, 4); checkOutput("wrap_1", int'(count_out), 1);
      checkOutput("model_pin_wrap", exp_count, 1);

      applyStimulus(2'b00, 4);
      doLoad(4'h0);
      checkOutput("load_0", int'(count_out), 0);
      applyStimulus(2'b01, 4);
      checkOutput("down_f", int'(count_out), 15);
      checkOutput("down_dir", int'(dir), 0);
      checkOutput("down_max", int'(max_count), 1);

      applyStimulus(2'b00, 4);
      checkOutput("back_0", int'(count_out), 0);
      base = errs_seen;
      applyStimulus(2'b11, 4);
      checkOutput("ill_errs", errs_seen - base, 1);
      checkOutput("ill_count", int'(count_out), 0);
      checkOutput("ill_dir", int'(dir), 1);
      applyStimulus(2'b01, 4);
      checkOutput("after_ill", int'(count_out), 1);
      checkOutput("model_pin_ill", exp_count, 1);

      ce = 1'b0;
      base = steps_seen;
      applyStimulus(2'b00, 4);
      applyStimulus(2'b10, 4);
      checkOutput("ce0_steps", steps_seen - base, 2);
      checkOutput("ce0_count", int'(count_out), 1);

      ce = 1'b1;
      base = steps_seen;
      {ch_a, ch_b} = 2'b11;
      repeat (LAT) @(negedge clk);
      load_n = 1'b0;
      data_load = 4'h5;
      @(negedge clk);
      load_n = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("ld_step_count", int'(count_out), 5);
      checkOutput("ld_step_pulse", steps_seen - base, 1);

      base = steps_seen;
      applyStimulus(2'b01, 1);
      applyStimulus(2'b11, 6);
`ifdef QDEC_GLITCH_FILTER_EN
      checkOutput("glitch_steps", steps_seen - base, 0);
      checkOutput("glitch_count", int'(count_out), 5);
      applyStimulus(2'b01, 6);
      checkOutput("stable_count", int'(count_out), 6);
`else
      checkOutput("glitch_steps", steps_seen - base, 2);
      checkOutput("glitch_count", int'(count_out), 5);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/quad_decoder.md
Name: quad_decoder

Overview:
- Quadrature decoder with an integrated position counter.
- Converts the two-phase channels A/B of an incremental encoder into up/down count steps. These are the same direction and enable events that drive the team's loadable up/down counter.
- Tracks position in a WIDTH-bit wrap-around register with max/zero flags and flags illegal phase jumps.
- Sits between the encoder input pins and position/control logic.

Parameters:
- WIDTH, 4, width of position counter and load data.
- SYNC_STAGES, 2, synchronizer flops per channel (minimum 2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ch_a  in  1  encoder phase A, asynchronous
- ch_b  in  1  encoder phase B, asynchronous
- load_n  in  1  active-low synchronous load of data_load
- data_load  in  WIDTH  position load value
- ce  in  1  count enable
- count_out  out  WIDTH  current position
- step  out  1  one-cycle pulse per valid decoded transition
- dir  out  1  direction of the last valid step: 1 = up, 0 = down
- err  out  1  one-cycle pulse on an illegal transition
- max_count  out  1  count_out == all ones (combinational from count_out)
- zero  out  1  count_out == 0 (combinational from count_out)

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: count_out = 0, step = 0, dir = 0, err = 0, zero = 1, max_count = 0.
- Synchronizer flops have no reset and sample continuously.
- During rst, the previous-phase register loads the synchronized {A,B}, so no spurious step or err occurs after reset release.
- Phase state is {A,B}.
  - Up sequence: 00 -> 10 -> 11 -> 01 -> 00 (A leads).
  - Down sequence is the reverse.
  - No change: no event.
  - Both bits changed: illegal. err pulses, no count, dir holds, previous phase updates to the new value.
- Latency (SYNC_STAGES = 2): an input change that is stable before rising edge k appears on count_out/step/err after edge k+2.
- step and dir reflect decode independently of ce and load_n.
- Count update priority, evaluated each edge:
  1. rst
  2. load_n == 0: count_out = data_load. A coincident step is dropped from the count but still pulses step.
  3. ce == 1 and valid step: count_out +1 if up, -1 if down.
  4. Otherwise hold.
- Arithmetic is modulo 2^WIDTH:
  - up from all ones -> 0
  - down from 0 -> all ones
- Reset asserted mid-sequence: state is cleared at that edge. Decoding resumes from the current phase with no event.

Optional Feature:
- Macro: QDEC_GLITCH_FILTER_EN.
- Defined: a newly synchronized {A,B} value is accepted only after it is identical on 2 consecutive cycles.
  - Single-cycle pulses on either channel are ignored entirely.
  - Latency grows by one cycle, to edge k+3.
- Undefined: no filter; the latency above applies.

Decomposition:
- Package qdec_pkg:
  - typedef enum for phase {PH00, PH10, PH11, PH01}
  - typedef enum step_e {STEP_NONE, STEP_UP, STEP_DOWN, STEP_ILLEGAL}
  - pure function decoding (prev, curr) -> step_e
- Sub-module qdec_sync: parameterized SYNC_STAGES synchronizer, one instance per channel. It also hosts the glitch filter when QDEC_GLITCH_FILTER_EN is defined.

Test Plan:
- Reset then idle: rst = 1 for 1 cycle with A/B = 11 held, then release -> count_out = 0, zero = 1, no step/err for 10 cycles.
- Four up transitions (00, 10, 11, 01, 00), each held 4 cycles, ce = 1 -> count_out 1, 2, 3, 4; dir = 1; 4 step pulses, each 3 edges after its input change.
- Load 4'hE, then 3 up steps -> count_out E, F (max_count = 1), 0 (zero = 1), 1.
- From count_out = 0, one down step (00 -> 01) -> count_out = F, dir = 0, max_count = 1.
- Illegal jump 00 -> 11 -> err pulses once, count and dir unchanged. A subsequent 11 -> 01 is decoded as an up step.
- ce = 0 with 2 up steps -> 2 step pulses, count unchanged.
- load_n = 0 with data_load = 5 on the same edge as a step -> count_out = 5.
- With QDEC_GLITCH_FILTER_EN: 1-cycle A pulse -> no step. A 2-cycle-stable change -> step.
